// File: rtl/sim_run_ctrl.sv
// Run controller for CPU top-level simulation and FPGA bring-up: sequences the
// CPU reset, counts run cycles, decodes the CPU UART TX line and ends the run
// on a terminator byte (pass) or on cycle-budget expiry (timeout).
module sim_run_ctrl #(
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned DATA_BITS      = 8,
  parameter logic [7:0]  END_CHAR       = 8'h04,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
  parameter int unsigned CNT_W          = 32,
  parameter bit          HOLD_ON_DONE   = 1'b1
) (
  input  logic                 sysclk,
  input  logic                 sys_reset,
  input  logic                 uart_rx_in,
  output logic                 cpu_resetn,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic [15:0]          char_count,
  output logic [CNT_W-1:0]     cycle_count,
  output logic                 run_done,
  output logic                 run_pass,
  output logic                 run_timeout
);

  localparam int unsigned HW = $clog2(RESET_CYCLES + 1);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [HW-1:0]        HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [BW-1:0]        HALF_BIT  = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]        FULL_BIT  = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0]        LAST_IDX  = IW'(DATA_BITS - 1);
  localparam logic [DATA_BITS-1:0] END_CMP   = END_CHAR[DATA_BITS-1:0];
  localparam bit                   TO_EN     = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [CNT_W-1:0]     TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [1:0] {CTL_HOLD, CTL_RUN, CTL_DONE} ctl_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // ---------------- control path state ----------------
  ctl_state_e         ctl_q, ctl_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic               cpu_rstn_q, cpu_rstn_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               tout_q, tout_d;

  // ---------------- UART path state ----------------
  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_e            rx_st_q, rx_st_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [IW-1:0]        bidx_q, bidx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 wait_hi_q, wait_hi_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 ferr_q, ferr_d;
  logic [15:0]          chars_q, chars_d;

  assign rx_s = sync_q[1];

  // Two-flop synchroniser for the asynchronous UART line; resets to idle-high.
  always_ff @(posedge sysclk) begin
    if (sys_reset) sync_q <= 2'b11;
    else           sync_q <= {sync_q[0], uart_rx_in};
  end

  // Control FSM next state: reset hold count, run-cycle count, end-of-run decision.
  always_comb begin
    ctl_d  = ctl_q;
    hold_d = hold_q;
    cyc_d  = cyc_q;
    pass_d = pass_q;
    tout_d = tout_q;
    case (ctl_q)
      CTL_HOLD: begin
        if (hold_q == HOLD_LAST) ctl_d = CTL_RUN;
        else                     hold_d = hold_q + 1'b1;
      end
      CTL_RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
        // Terminator takes priority over a same-cycle budget expiry.
        if (rx_valid_q && (rx_data_q == END_CMP)) begin
          ctl_d  = CTL_DONE;
          pass_d = 1'b1;
        end else if (TO_EN && (cyc_q == TO_LAST)) begin
          ctl_d  = CTL_DONE;
          tout_d = 1'b1;
        end
      end
      default: ;  // DONE is terminal: counters and flags frozen
    endcase
    done_d     = (ctl_d == CTL_DONE);
    cpu_rstn_d = (ctl_d == CTL_RUN) || ((ctl_d == CTL_DONE) && !HOLD_ON_DONE);
  end

  // Control FSM registers.
  always_ff @(posedge sysclk) begin
    if (sys_reset) begin
      ctl_q      <= CTL_HOLD;
      hold_q     <= '0;
      cyc_q      <= '0;
      cpu_rstn_q <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      ctl_q      <= ctl_d;
      hold_q     <= hold_d;
      cyc_q      <= cyc_d;
      cpu_rstn_q <= cpu_rstn_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      tout_q     <= tout_d;
    end
  end

  // UART RX FSM next state: mid-bit sampling, LSB-first shift, stop-bit check.
  always_comb begin
    rx_st_d    = rx_st_q;
    bcnt_d     = bcnt_q;
    bidx_d     = bidx_q;
    shift_d    = shift_q;
    wait_hi_d  = wait_hi_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    ferr_d     = 1'b0;
    chars_d    = chars_q;
    case (rx_st_q)
      RX_IDLE: begin
        // After a framing error the line must return high before a new start
        // bit counts, so a held-low break yields one error and nothing more.
        if (wait_hi_q) begin
          if (rx_s) wait_hi_d = 1'b0;
        end else if (!rx_s) begin
          rx_st_d = RX_START;
          bcnt_d  = HALF_BIT;
        end
      end
      RX_START: begin
        if (bcnt_q == '0) begin
          if (rx_s) begin
            rx_st_d = RX_IDLE;  // glitch shorter than half a bit
          end else begin
            rx_st_d = RX_DATA;
            bcnt_d  = FULL_BIT;
            bidx_d  = '0;
          end
        end else begin
          bcnt_d = bcnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (bcnt_q == '0) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bcnt_d  = FULL_BIT;
          if (bidx_q == LAST_IDX) rx_st_d = RX_STOP;
          else                    bidx_d  = bidx_q + 1'b1;
        end else begin
          bcnt_d = bcnt_q - 1'b1;
        end
      end
      default: begin  // RX_STOP
        if (bcnt_q == '0) begin
          rx_st_d = RX_IDLE;
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            if (chars_q != 16'hFFFF) chars_d = chars_q + 16'd1;
          end else begin
            ferr_d    = 1'b1;
            wait_hi_d = 1'b1;
          end
        end else begin
          bcnt_d = bcnt_q - 1'b1;
        end
      end
    endcase
  end

  // UART RX FSM registers.
  always_ff @(posedge sysclk) begin
    if (sys_reset) begin
      rx_st_q    <= RX_IDLE;
      bcnt_q     <= '0;
      bidx_q     <= '0;
      shift_q    <= '0;
      wait_hi_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      chars_q    <= '0;
    end else begin
      rx_st_q    <= rx_st_d;
      bcnt_q     <= bcnt_d;
      bidx_q     <= bidx_d;
      shift_q    <= shift_d;
      wait_hi_q  <= wait_hi_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_d;
      chars_q    <= chars_d;
    end
  end

  assign cpu_resetn  = cpu_rstn_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = ferr_q;
  assign char_count  = chars_q;
  assign cycle_count = cyc_q;
  assign run_done    = done_q;
  assign run_pass    = pass_q;
  assign run_timeout = tout_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: DUT A uses the default parameters, DUT B uses a short
// bit period and a 1000-cycle budget. Received bytes are checked through a
// per-DUT expected-byte queue filled when a frame is sent.
module tb_sim_run_ctrl;

  localparam int CPB_A = 868;
  localparam int CPB_B = 16;

  logic sysclk = 1'b0;
  logic rst_a  = 1'b1;
  logic rst_b  = 1'b1;
  logic line_a = 1'b1;
  logic line_b = 1'b1;

  logic        a_cpu_resetn, a_rx_valid, a_frame_err, a_run_done, a_run_pass, a_run_timeout;
  logic [7:0]  a_rx_data;
  logic [15:0] a_char_count;
  logic [31:0] a_cycle_count;
  logic        b_cpu_resetn, b_rx_valid, b_frame_err, b_run_done, b_run_pass, b_run_timeout;
  logic [7:0]  b_rx_data;
  logic [15:0] b_char_count;
  logic [31:0] b_cycle_count;

  always #5 sysclk = ~sysclk;

  sim_run_ctrl u_dut_a (
    .sysclk(sysclk), .sys_reset(rst_a), .uart_rx_in(line_a),
    .cpu_resetn(a_cpu_resetn), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
    .frame_err(a_frame_err), .char_count(a_char_count), .cycle_count(a_cycle_count),
    .run_done(a_run_done), .run_pass(a_run_pass), .run_timeout(a_run_timeout)
  );

  sim_run_ctrl #(.CLKS_PER_BIT(CPB_B), .TIMEOUT_CYCLES(32'd1000)) u_dut_b (
    .sysclk(sysclk), .sys_reset(rst_b), .uart_rx_in(line_b),
    .cpu_resetn(b_cpu_resetn), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .frame_err(b_frame_err), .char_count(b_char_count), .cycle_count(b_cycle_count),
    .run_done(b_run_done), .run_pass(b_run_pass), .run_timeout(b_run_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int fe_b_n  = 0;
  int rxv_b_n = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every received byte must match the oldest expected byte.
  always @(negedge sysclk) begin
    if (a_rx_valid) begin
      check_eq("a_sb_nonempty", (q_a.size() != 0), 1);
      if (q_a.size() != 0) check_eq("a_rx_byte", a_rx_data, q_a.pop_front());
    end
    if (b_rx_valid) begin
      rxv_b_n++;
      check_eq("b_sb_nonempty", (q_b.size() != 0), 1);
      if (q_b.size() != 0) check_eq("b_rx_byte", b_rx_data, q_b.pop_front());
    end
    if (b_frame_err) fe_b_n++;
  end

  task automatic set_line(input bit to_b, input logic v);
    if (to_b) line_b = v;
    else      line_a = v;
  endtask

  task automatic send_frame(input bit to_b, input logic [7:0] data, input logic stop_bit);
    int cpb;
    logic [9:0] bits;
    cpb  = to_b ? CPB_B : CPB_A;
    bits = {stop_bit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_line(to_b, bits[i]);
      repeat (cpb) @(negedge sysclk);
    end
    set_line(to_b, 1'b1);
  endtask

  task automatic wait_drain(input bit to_b, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((to_b ? q_b.size() : q_a.size()) == 0) break;
      @(negedge sysclk);
    end
    if (to_b) check_eq("b_sb_drained", q_b.size(), 0);
    else      check_eq("a_sb_drained", q_a.size(), 0);
  endtask

  initial begin
    logic [31:0] c0;
    int fe0, rx0;

    // Reset state
    repeat (4) @(negedge sysclk);
    check_eq("rst_cpu_resetn", a_cpu_resetn, 0);
    check_eq("rst_rx_valid",   a_rx_valid, 0);
    check_eq("rst_frame_err",  a_frame_err, 0);
    check_eq("rst_rx_data",    a_rx_data, 0);
    check_eq("rst_char_count", a_char_count, 0);
    check_eq("rst_cycle_cnt",  a_cycle_count, 0);
    check_eq("rst_flags",      {a_run_done, a_run_pass, a_run_timeout}, 0);

    // cpu_resetn rises exactly 16 cycles after reset release
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (15) @(negedge sysclk);
    check_eq("hold_cyc15_low", a_cpu_resetn, 0);
    @(negedge sysclk);
    check_eq("hold_cyc16_high", a_cpu_resetn, 1);
    check_eq("run_entry_cycle_cnt", a_cycle_count, 0);

    // DUT B: idle line, budget expires
    for (int i = 0; i < 1200 && !b_run_done; i++) @(negedge sysclk);
    check_eq("b_to_done",      b_run_done, 1);
    check_eq("b_to_flag",      b_run_timeout, 1);
    check_eq("b_to_pass",      b_run_pass, 0);
    check_eq("b_to_cycle_cnt", b_cycle_count, 1000);
    check_eq("b_to_cpu_rstn",  b_cpu_resetn, 0);

    // DUT A: two ordinary characters
    q_a.push_back(8'h48);
    send_frame(1'b0, 8'h48, 1'b1);
    q_a.push_back(8'h69);
    send_frame(1'b0, 8'h69, 1'b1);
    wait_drain(1'b0, 4 * CPB_A);
    check_eq("a_char_count_2", a_char_count, 2);
    check_eq("a_not_done",     a_run_done, 0);
    check_eq("a_cpu_running",  a_cpu_resetn, 1);

    // DUT A: terminator ends the run as a pass
    q_a.push_back(8'h04);
    send_frame(1'b0, 8'h04, 1'b1);
    for (int i = 0; i < 4 * CPB_A && !a_run_done; i++) @(negedge sysclk);
    check_eq("a_done",       a_run_done, 1);
    check_eq("a_pass",       a_run_pass, 1);
    check_eq("a_no_timeout", a_run_timeout, 0);
    check_eq("a_cpu_held",   a_cpu_resetn, 0);
    check_eq("a_char_count_3", a_char_count, 3);
    c0 = a_cycle_count;
    repeat (100) @(negedge sysclk);
    check_eq("a_cycle_frozen", a_cycle_count, c0);
    wait_drain(1'b0, 10);

    // DUT B: terminator after timeout decodes but does not flip to pass
    q_b.push_back(8'h04);
    send_frame(1'b1, 8'h04, 1'b1);
    wait_drain(1'b1, 4 * CPB_B);
    check_eq("b_late_pass",  b_run_pass, 0);
    check_eq("b_late_count", b_char_count, 1);
    check_eq("b_cycle_still_1000", b_cycle_count, 1000);

    // DUT B: short low glitch is rejected
    fe0 = fe_b_n; rx0 = rxv_b_n;
    line_b = 1'b0;
    repeat (5) @(negedge sysclk);
    line_b = 1'b1;
    repeat (12 * CPB_B) @(negedge sysclk);
    check_eq("glitch_no_rx", rxv_b_n, rx0);
    check_eq("glitch_no_fe", fe_b_n, fe0);

    // DUT B: stop bit 0 gives one framing error, no character
    send_frame(1'b1, 8'hA5, 1'b0);
    repeat (2 * CPB_B) @(negedge sysclk);
    check_eq("bad_stop_fe",    fe_b_n, fe0 + 1);
    check_eq("bad_stop_rx",    rxv_b_n, rx0);
    check_eq("bad_stop_count", b_char_count, 1);
    check_eq("bad_stop_data",  b_rx_data, 8'h04);

    // DUT B: held-low break yields exactly one framing error
    line_b = 1'b0;
    repeat (30 * CPB_B) @(negedge sysclk);
    line_b = 1'b1;
    repeat (2 * CPB_B) @(negedge sysclk);
    check_eq("break_fe", fe_b_n, fe0 + 2);
    check_eq("break_rx", rxv_b_n, rx0);

    // DUT B: reset mid-frame, then a clean frame
    line_b = 1'b0;
    repeat (4 * CPB_B) @(negedge sysclk);
    rst_b  = 1'b1;
    line_b = 1'b1;
    @(negedge sysclk);
    check_eq("mid_rst_outputs",
             {b_cpu_resetn, b_rx_valid, b_frame_err, b_run_done, b_run_pass, b_run_timeout}, 0);
    check_eq("mid_rst_data",   b_rx_data, 0);
    check_eq("mid_rst_count",  b_char_count, 0);
    check_eq("mid_rst_cycles", b_cycle_count, 0);
    rst_b = 1'b0;
    repeat (2 * CPB_B) @(negedge sysclk);
    q_b.push_back(8'h5A);
    send_frame(1'b1, 8'h5A, 1'b1);
    wait_drain(1'b1, 4 * CPB_B);
    check_eq("post_rst_count", b_char_count, 1);
    check_eq("post_rst_data",  b_rx_data, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
